// File: rtl/rs_dispatcher.sv
// rs_dispatcher
//   Dispatch stage between the decode queue and one reservation station.
//   Renames source operands through a per-register status table, allocates
//   a ROB slot, resolves each operand from the register file, the CDB or the
//   ROB, and parks the finished entry in a single hold register until the
//   reservation station can take it. The held entry snoops the CDB while
//   it waits.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   flush                 mispredict flush (drops hold entry, clears busy bits)
//   in_*                  decode entry and valid/ready handshake
//   rf_raddr*/rf_rdata*   combinational register file read
//   rob_alloc_*           ROB slot allocation
//   rob_qtag*/rob_q*      ROB operand query (tag out, ready/value back)
//   cdb_*                 common data bus broadcast
//   commit_*              ROB commit, releases the status table entry
//   rs_full, push_ce      reservation station back-pressure and push strobe
//   op,tag*,val*,target   held entry presented to the reservation station
module rs_dispatcher #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 6,
  parameter int TAG_W  = 4,
  parameter int REG_N  = 32,
  localparam int REG_W = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,

  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [REG_W-1:0]  in_rs1,
  input  logic [REG_W-1:0]  in_rs2,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,

  output logic [REG_W-1:0]  rf_raddr1,
  output logic [REG_W-1:0]  rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,

  input  logic              rob_alloc_ready,
  input  logic [TAG_W-1:0]  rob_alloc_tag,
  output logic              rob_alloc_ce,
  output logic [TAG_W-1:0]  rob_qtag1,
  output logic [TAG_W-1:0]  rob_qtag2,
  input  logic              rob_qready1,
  input  logic              rob_qready2,
  input  logic [DATA_W-1:0] rob_qval1,
  input  logic [DATA_W-1:0] rob_qval2,

  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_val,

  input  logic              commit_valid,
  input  logic [REG_W-1:0]  commit_rd,
  input  logic [TAG_W-1:0]  commit_tag,

  input  logic              rs_full,
  output logic              push_ce,
  output logic [OP_W-1:0]   op,
  output logic [TAG_W-1:0]  tag1,
  output logic [TAG_W-1:0]  tag2,
  output logic [DATA_W-1:0] val1,
  output logic [DATA_W-1:0] val2,
  output logic [TAG_W-1:0]  target
);

  // Register status table
  logic [REG_N-1:0] busy_q, busy_d;
  logic [TAG_W-1:0] rtag_q [REG_N];
  logic [TAG_W-1:0] rtag_d [REG_N];

  // Hold register
  logic              hold_valid_q, hold_valid_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [TAG_W-1:0]  tag1_q, tag1_d;
  logic [TAG_W-1:0]  tag2_q, tag2_d;
  logic [DATA_W-1:0] val1_q, val1_d;
  logic [DATA_W-1:0] val2_q, val2_d;
  logic [TAG_W-1:0]  target_q, target_d;

  logic              accept;
  logic [TAG_W-1:0]  res_tag1, res_tag2;
  logic [DATA_W-1:0] res_val1, res_val2;

  // Handshake
  assign in_ready     = rob_alloc_ready & ~flush & (~hold_valid_q | ~rs_full);
  assign accept       = in_valid & in_ready;
  assign rob_alloc_ce = accept;
  assign push_ce      = hold_valid_q & ~rs_full & ~flush;

  assign rf_raddr1 = in_rs1;
  assign rf_raddr2 = in_rs2;
  assign rob_qtag1 = rtag_q[in_rs1];
  assign rob_qtag2 = rtag_q[in_rs2];

  assign op     = op_q;
  assign tag1   = tag1_q;
  assign tag2   = tag2_q;
  assign val1   = val1_q;
  assign val2   = val2_q;
  assign target = target_q;

  // Operand resolution reads the table before this cycle's rename, so an
  // instruction that overwrites one of its own sources still waits on the
  // previous producer.
  always_comb begin
    res_tag1 = '0;
    res_val1 = '0;
    if (in_rs1 != '0) begin
      if (!busy_q[in_rs1])
        res_val1 = rf_rdata1;
      else if (cdb_valid && (cdb_tag == rtag_q[in_rs1]))
        res_val1 = cdb_val;
      else if (rob_qready1)
        res_val1 = rob_qval1;
      else
        res_tag1 = rtag_q[in_rs1];
    end
  end

  // r0 takes precedence over the immediate select.
  always_comb begin
    res_tag2 = '0;
    res_val2 = '0;
    if (in_rs2 != '0) begin
      if (in_use_imm)
        res_val2 = in_imm;
      else if (!busy_q[in_rs2])
        res_val2 = rf_rdata2;
      else if (cdb_valid && (cdb_tag == rtag_q[in_rs2]))
        res_val2 = cdb_val;
      else if (rob_qready2)
        res_val2 = rob_qval2;
      else
        res_tag2 = rtag_q[in_rs2];
    end
  end

  // Status table update. Commit is applied first so that a rename of the
  // same register on the same edge overrides the release.
  always_comb begin
    busy_d = busy_q;
    rtag_d = rtag_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (commit_valid && busy_q[commit_rd] && (rtag_q[commit_rd] == commit_tag))
        busy_d[commit_rd] = 1'b0;
      if (accept && (in_rd != '0)) begin
        busy_d[in_rd] = 1'b1;
        rtag_d[in_rd] = rob_alloc_tag;
      end
    end
  end

  // Hold register. A broadcast on the push edge is left to the reservation
  // station, which sees the same CDB cycle.
  always_comb begin
    hold_valid_d = hold_valid_q;
    op_d         = op_q;
    tag1_d       = tag1_q;
    tag2_d       = tag2_q;
    val1_d       = val1_q;
    val2_d       = val2_q;
    target_d     = target_q;
    if (flush) begin
      hold_valid_d = 1'b0;
    end else if (accept) begin
      hold_valid_d = 1'b1;
      op_d         = in_op;
      tag1_d       = res_tag1;
      tag2_d       = res_tag2;
      val1_d       = res_val1;
      val2_d       = res_val2;
      target_d     = rob_alloc_tag;
    end else if (push_ce) begin
      hold_valid_d = 1'b0;
    end else if (hold_valid_q && cdb_valid) begin
      if ((tag1_q != '0) && (tag1_q == cdb_tag)) begin
        tag1_d = '0;
        val1_d = cdb_val;
      end
      if ((tag2_q != '0) && (tag2_q == cdb_tag)) begin
        tag2_d = '0;
        val2_d = cdb_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= '0;
      for (int i = 0; i < REG_N; i++) rtag_q[i] <= '0;
      hold_valid_q <= 1'b0;
      op_q         <= '0;
      tag1_q       <= '0;
      tag2_q       <= '0;
      val1_q       <= '0;
      val2_q       <= '0;
      target_q     <= '0;
    end else begin
      busy_q       <= busy_d;
      rtag_q       <= rtag_d;
      hold_valid_q <= hold_valid_d;
      op_q         <= op_d;
      tag1_q       <= tag1_d;
      tag2_q       <= tag2_d;
      val1_q       <= val1_d;
      val2_q       <= val2_d;
      target_q     <= target_d;
    end
  end

endmodule

// File: tb/tb_rs_dispatcher.sv
module tb_rs_dispatcher;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        in_valid, in_ready;
  logic [5:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic        in_use_imm;
  logic [31:0] in_imm;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        rob_alloc_ready, rob_alloc_ce;
  logic [3:0]  rob_alloc_tag, rob_qtag1, rob_qtag2;
  logic        rob_qready1, rob_qready2;
  logic [31:0] rob_qval1, rob_qval2;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_val;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [3:0]  commit_tag;
  logic        rs_full, push_ce;
  logic [5:0]  op;
  logic [3:0]  tag1, tag2, target;
  logic [31:0] val1, val2;

  always #5 clk = ~clk;

  rs_dispatcher dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rob_alloc_ready(rob_alloc_ready), .rob_alloc_tag(rob_alloc_tag),
    .rob_alloc_ce(rob_alloc_ce),
    .rob_qtag1(rob_qtag1), .rob_qtag2(rob_qtag2),
    .rob_qready1(rob_qready1), .rob_qready2(rob_qready2),
    .rob_qval1(rob_qval1), .rob_qval2(rob_qval2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
    .rs_full(rs_full), .push_ce(push_ce), .op(op),
    .tag1(tag1), .tag2(tag2), .val1(val1), .val2(val2), .target(target)
  );

  typedef struct {
    logic        iv;
    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic        imm_en;
    logic [31:0] imm, rd1, rd2;
    logic        ardy;
    logic [3:0]  atag;
    logic        qr1, qr2;
    logic [31:0] qv1, qv2;
    logic        cv;
    logic [3:0]  ct;
    logic [31:0] cval;
    logic        cm;
    logic [4:0]  cmrd;
    logic [3:0]  cmt;
    logic        full, fl;
    // expected, sampled before the edge of the cycle the row is applied
    logic        e_rdy, e_push;
    logic [3:0]  e_q1, e_q2;
    logic        chk;
    logic [5:0]  e_op;
    logic [3:0]  e_t1, e_t2, e_tgt;
    logic [31:0] e_v1, e_v2;
  } row_t;

  row_t tbl[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic row_t idle();
    row_t r;
    r.iv = 0; r.op = 0; r.rd = 0; r.rs1 = 0; r.rs2 = 0;
    r.imm_en = 0; r.imm = 0; r.rd1 = 0; r.rd2 = 0;
    r.ardy = 1; r.atag = 1; r.qr1 = 0; r.qr2 = 0; r.qv1 = 0; r.qv2 = 0;
    r.cv = 0; r.ct = 0; r.cval = 0; r.cm = 0; r.cmrd = 0; r.cmt = 0;
    r.full = 0; r.fl = 0;
    r.e_rdy = 1; r.e_push = 0; r.e_q1 = 0; r.e_q2 = 0; r.chk = 0;
    r.e_op = 0; r.e_t1 = 0; r.e_t2 = 0; r.e_tgt = 0; r.e_v1 = 0; r.e_v2 = 0;
    return r;
  endfunction

  function automatic row_t acc(row_t r, logic [5:0] o, logic [4:0] d,
                               logic [4:0] s1, logic [4:0] s2, logic [3:0] t);
    r.iv = 1; r.op = o; r.rd = d; r.rs1 = s1; r.rs2 = s2; r.atag = t;
    return r;
  endfunction

  function automatic row_t hold(row_t r, logic [5:0] o, logic [3:0] t1, logic [3:0] t2,
                                logic [31:0] v1, logic [31:0] v2, logic [3:0] tg);
    r.chk = 1; r.e_op = o; r.e_t1 = t1; r.e_t2 = t2;
    r.e_v1 = v1; r.e_v2 = v2; r.e_tgt = tg;
    return r;
  endfunction

  task automatic apply(input row_t r);
    in_valid = r.iv; in_op = r.op; in_rd = r.rd; in_rs1 = r.rs1; in_rs2 = r.rs2;
    in_use_imm = r.imm_en; in_imm = r.imm; rf_rdata1 = r.rd1; rf_rdata2 = r.rd2;
    rob_alloc_ready = r.ardy; rob_alloc_tag = r.atag;
    rob_qready1 = r.qr1; rob_qready2 = r.qr2; rob_qval1 = r.qv1; rob_qval2 = r.qv2;
    cdb_valid = r.cv; cdb_tag = r.ct; cdb_val = r.cval;
    commit_valid = r.cm; commit_rd = r.cmrd; commit_tag = r.cmt;
    rs_full = r.full; flush = r.fl;
  endtask

  task automatic chk(input string nm, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", nm, row, act, exp);
    else
      n_pass++;
  endtask

  initial begin
    row_t r;

    // R0 state straight out of reset
    r = idle(); r = hold(r, 0, 0, 0, 0, 0, 0); tbl.push_back(r);
    // R1 add r3,r1,r2 -> tag 1
    r = idle(); r = acc(r, 6'h01, 3, 1, 2, 1); r.rd1 = 5; r.rd2 = 7;
    r = hold(r, 0, 0, 0, 0, 0, 0); tbl.push_back(r);
    // R2 push add; accept sub r4,r3,r3 -> tag 2 (r3 pending on tag 1)
    r = idle(); r = acc(r, 6'h02, 4, 3, 3, 2); r.rd1 = 32'h55; r.rd2 = 32'h55;
    r.e_push = 1; r.e_q1 = 1; r.e_q2 = 1; r = hold(r, 6'h01, 0, 0, 5, 7, 1); tbl.push_back(r);
    // R3 stall, unrelated CDB tag must not snoop, offered entry refused
    r = idle(); r.full = 1; r = acc(r, 6'h06, 6, 0, 0, 3); r.cv = 1; r.ct = 7; r.cval = 32'hDEAD;
    r.e_rdy = 0; r = hold(r, 6'h02, 1, 1, 0, 0, 2); tbl.push_back(r);
    // R4 stall, CDB tag 1 = 0x2A
    r = idle(); r.full = 1; r.cv = 1; r.ct = 1; r.cval = 32'h2A;
    r.e_rdy = 0; r = hold(r, 6'h02, 1, 1, 0, 0, 2); tbl.push_back(r);
    // R5 snooped values visible, still stalled
    r = idle(); r.full = 1; r.e_rdy = 0; r = hold(r, 6'h02, 0, 0, 32'h2A, 32'h2A, 2); tbl.push_back(r);
    // R6 rs_full drops -> push
    r = idle(); r.e_push = 1; r = hold(r, 6'h02, 0, 0, 32'h2A, 32'h2A, 2); tbl.push_back(r);
    // R7 single push only; ROB full refuses entry
    r = idle(); r = acc(r, 6'h3E, 11, 0, 0, 5); r.ardy = 0; r.e_rdy = 0; tbl.push_back(r);
    // R8 accept reading r3 with same-cycle CDB tag 1 = 9
    r = idle(); r = acc(r, 6'h03, 7, 3, 1, 3); r.rd1 = 32'h66; r.rd2 = 11;
    r.cv = 1; r.ct = 1; r.cval = 9; r.e_q1 = 1; tbl.push_back(r);
    // R9
    r = idle(); r.e_push = 1; r = hold(r, 6'h03, 0, 0, 9, 11, 3); tbl.push_back(r);
    // R10 ROB-ready operand and immediate operand 2
    r = idle(); r = acc(r, 6'h04, 8, 4, 5, 4); r.imm_en = 1; r.imm = 32'h100;
    r.qr1 = 1; r.qv1 = 32'h77; r.rd1 = 32'h66; r.e_q1 = 2; tbl.push_back(r);
    // R11 push + back-to-back accept, both sources pending
    r = idle(); r = acc(r, 6'h05, 9, 3, 4, 5); r.e_push = 1; r.e_q1 = 1; r.e_q2 = 2;
    r = hold(r, 6'h04, 0, 0, 32'h77, 32'h100, 4); tbl.push_back(r);
    // R12 stall
    r = idle(); r.full = 1; r.e_rdy = 0; r = hold(r, 6'h05, 1, 2, 0, 0, 5); tbl.push_back(r);
    // R13 flush mid-stall
    r = idle(); r.full = 1; r.fl = 1; r = acc(r, 6'h3D, 12, 0, 0, 6); r.e_rdy = 0;
    r = hold(r, 6'h05, 1, 2, 0, 0, 5); tbl.push_back(r);
    // R14 no push after flush; r3/r9 no longer busy -> register file
    r = idle(); r = acc(r, 6'h06, 10, 3, 9, 6); r.rd1 = 32'h33; r.rd2 = 32'h44;
    r.e_q1 = 1; r.e_q2 = 5; tbl.push_back(r);
    // R15
    r = idle(); r = acc(r, 6'h07, 0, 0, 0, 7); r.e_push = 1;
    r = hold(r, 6'h06, 0, 0, 32'h33, 32'h44, 6); tbl.push_back(r);
    // R16 flush with rs_full low must not push
    r = idle(); r.fl = 1; r.e_rdy = 0; r = hold(r, 6'h07, 0, 0, 0, 0, 7); tbl.push_back(r);
    // R17
    r = idle(); tbl.push_back(r);
    // R18 r5 -> tag 3
    r = idle(); r = acc(r, 6'h08, 5, 0, 0, 3); tbl.push_back(r);
    // R19 r5 -> tag 4, sources r5 see old producer
    r = idle(); r = acc(r, 6'h09, 5, 5, 5, 4); r.e_push = 1; r.e_q1 = 3; r.e_q2 = 3;
    r = hold(r, 6'h08, 0, 0, 0, 0, 3); tbl.push_back(r);
    // R20 stale commit of tag 3
    r = idle(); r.cm = 1; r.cmrd = 5; r.cmt = 3; r.e_push = 1;
    r = hold(r, 6'h09, 3, 3, 0, 0, 4); tbl.push_back(r);
    // R21 r5 still busy on tag 4
    r = idle(); r = acc(r, 6'h0A, 0, 5, 0, 5); r.rd1 = 32'h99; r.e_q1 = 4; tbl.push_back(r);
    // R22 commit tag 4
    r = idle(); r.cm = 1; r.cmrd = 5; r.cmt = 4; r.e_push = 1;
    r = hold(r, 6'h0A, 4, 0, 0, 0, 5); tbl.push_back(r);
    // R23 r5 released
    r = idle(); r = acc(r, 6'h0B, 0, 5, 0, 6); r.rd1 = 32'h99; r.e_q1 = 4; tbl.push_back(r);
    // R24 r5 -> tag 7
    r = idle(); r = acc(r, 6'h0C, 5, 0, 0, 7); r.e_push = 1;
    r = hold(r, 6'h0B, 0, 0, 32'h99, 0, 6); tbl.push_back(r);
    // R25 commit tag 7 with same-cycle rename of r5 to tag 8
    r = idle(); r = acc(r, 6'h0D, 5, 0, 0, 8); r.cm = 1; r.cmrd = 5; r.cmt = 7; r.e_push = 1;
    r = hold(r, 6'h0C, 0, 0, 0, 0, 7); tbl.push_back(r);
    // R26
    r = idle(); r = acc(r, 6'h0E, 0, 5, 0, 9); r.rd1 = 32'h99; r.e_q1 = 8; r.e_push = 1;
    r = hold(r, 6'h0D, 0, 0, 0, 0, 8); tbl.push_back(r);
    // R27
    r = idle(); r.e_push = 1; r = hold(r, 6'h0E, 8, 0, 0, 0, 9); tbl.push_back(r);
    // R28
    r = idle(); tbl.push_back(r);

    // reset
    apply(idle());
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_push_ce", -1, push_ce, 0);
    chk("rst_op", -1, op, 0);
    chk("rst_tag1", -1, tag1, 0);
    chk("rst_tag2", -1, tag2, 0);
    chk("rst_val1", -1, val1, 0);
    chk("rst_val2", -1, val2, 0);
    chk("rst_target", -1, target, 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      apply(tbl[i]);
      #1;
      chk("in_ready", i, in_ready, tbl[i].e_rdy);
      chk("push_ce", i, push_ce, tbl[i].e_push);
      chk("rob_alloc_ce", i, rob_alloc_ce, tbl[i].iv & tbl[i].e_rdy);
      chk("rob_qtag1", i, rob_qtag1, tbl[i].e_q1);
      chk("rob_qtag2", i, rob_qtag2, tbl[i].e_q2);
      chk("rf_raddr1", i, rf_raddr1, tbl[i].rs1);
      chk("rf_raddr2", i, rf_raddr2, tbl[i].rs2);
      if (tbl[i].chk) begin
        chk("op", i, op, tbl[i].e_op);
        chk("tag1", i, tag1, tbl[i].e_t1);
        chk("tag2", i, tag2, tbl[i].e_t2);
        chk("val1", i, val1, tbl[i].e_v1);
        chk("val2", i, val2, tbl[i].e_v2);
        chk("target", i, target, tbl[i].e_tgt);
      end
    end

    // reset asserted while an entry is stalled discards it and the table
    @(negedge clk);
    r = idle(); r = acc(r, 6'h3F, 2, 1, 1, 10); r.rd1 = 3; r.rd2 = 3;
    apply(r);
    @(negedge clk);
    r = idle(); r.full = 1; apply(r);
    #1;
    chk("stall_push_ce", 100, push_ce, 0);
    chk("stall_op", 100, op, 6'h3F);
    chk("stall_target", 100, target, 10);
    chk("stall_in_ready", 100, in_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rs_full = 1'b0;
    in_rs1 = 2;
    #1;
    chk("rst_stall_push_ce", 101, push_ce, 0);
    chk("rst_stall_op", 101, op, 0);
    chk("rst_stall_target", 101, target, 0);
    chk("rst_stall_qtag1", 101, rob_qtag1, 0);
    chk("rst_stall_in_ready", 101, in_ready, 1);
    @(posedge clk);
    @(negedge clk); #1;
    chk("rst_stall_no_push", 102, push_ce, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
